// File: rtl/seg_nios2_gen2_0_cpu_ocimem_ctrl.sv
// Nios II debug-monitor RAM controller: executes JTAG reads/writes and arbitrates a CPU Avalon-MM port
// onto one single-port RAM. Define SEG_OCIMEM_CPU_WRITE_EN to let CPU writes modify the RAM.
module seg_nios2_gen2_0_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [31:0]       dreg_q, dreg_d;
  logic [ADDR_W-1:0] areg_q, areg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              unused_ok;

`ifdef SEG_OCIMEM_CPU_WRITE_EN
  assign unused_ok = ^{jdo[37:36], jdo[2:0]};
`else
  assign unused_ok = ^{jdo[37:36], jdo[2:0], avs_writedata};
`endif

  // Single-port RAM: synchronous write, registered read (1-cycle latency)
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    pend_wr_d       = pend_wr_q;
    dreg_d          = dreg_q;
    areg_d          = areg_q;
    ready_d         = ready_q;
    error_d         = error_q;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    ram_addr        = avs_address;
    ram_wdata       = dreg_q;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;

    unique case (state_q)
      IDLE: begin
        if (pend_q && pend_wr_q) begin
          ram_we   = 1'b1;
          ram_addr = areg_q;
          areg_d   = areg_q + ADDR_W'(1);
          pend_d   = 1'b0;
          ready_d  = 1'b1;
        end else if (pend_q) begin
          ram_re   = 1'b1;
          ram_addr = areg_q;
          state_d  = JRD;
        end else if (avs_write && !avs_read) begin
          avs_waitrequest = 1'b0;
`ifdef SEG_OCIMEM_CPU_WRITE_EN
          ram_we    = 1'b1;
          ram_wdata = avs_writedata;
`else
          error_d   = 1'b1;
`endif
        end else if (avs_read) begin
          ram_re  = 1'b1;
          state_d = CRD;
        end
      end
      JRD: begin
        dreg_d  = ram_q;
        areg_d  = areg_q + ADDR_W'(1);
        pend_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      CRD: begin
        avs_waitrequest = 1'b0;
        avs_readdata    = ram_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are applied after the FSM so an address load overrides an auto-increment
    if (take_action_ocimem_a) begin
      areg_d  = jdo[17 +: ADDR_W];
      ready_d = 1'b0;
      if (jdo[35]) error_d = 1'b0;
    end else if (take_action_ocimem_b) begin
      if (pend_q) begin
        error_d = 1'b1;
      end else begin
        dreg_d    = jdo[34:3];
        pend_d    = 1'b1;
        pend_wr_d = 1'b1;
        ready_d   = 1'b0;
      end
    end else if (take_no_action_ocimem_a) begin
      if (pend_q) begin
        error_d = 1'b1;
      end else begin
        pend_d    = 1'b1;
        pend_wr_d = 1'b0;
        ready_d   = 1'b0;
      end
    end

    // An access in flight during reset is abandoned and must not touch the RAM
    if (reset) begin
      ram_we          = 1'b0;
      ram_re          = 1'b0;
      avs_waitrequest = 1'b1;
      avs_readdata    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
      dreg_q    <= '0;
      areg_q    <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      dreg_q    <= dreg_d;
      areg_q    <= areg_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  assign MonDReg       = dreg_q;
  assign MonAReg       = areg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule
